// File: rtl/reg_alu_pkg.sv
// Shared types and constants for the reg_alu controller: FSM states,
// instruction kind codes, instruction field positions and datapath widths.
package reg_alu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int OP_W   = 2;
  localparam int KIND_W = 3;
  localparam int IMM_W  = 8;

  localparam int KIND_MSB = 15;
  localparam int KIND_LSB = 13;
  localparam int OP_MSB   = 12;
  localparam int OP_LSB   = 11;
  localparam int WA_MSB   = 10;
  localparam int WA_LSB   = 8;
  localparam int RA_MSB   = 7;
  localparam int RA_LSB   = 5;
  localparam int RB_MSB   = 4;
  localparam int RB_LSB   = 2;
  localparam int IMM_MSB  = 7;

  localparam logic [KIND_W-1:0] K_NOP = 3'b000;
  localparam logic [KIND_W-1:0] K_LDI = 3'b001;
  localparam logic [KIND_W-1:0] K_ALU = 3'b010;
  localparam logic [KIND_W-1:0] K_RD  = 3'b011;
  localparam logic [KIND_W-1:0] K_CLC = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/reg_alu_ctrl_dec.sv
// Combinational instruction decoder for reg_alu_ctrl. Kind 100 is CLC
// (legal) only when REG_ALU_CTRL_CARRY_EN is defined; otherwise illegal.
module reg_alu_ctrl_dec
  import reg_alu_pkg::*;
(
  input  logic [DATA_W-1:0] i_instr,
  output logic [KIND_W-1:0] o_kind,
  output logic [ADDR_W-1:0] o_rd_a,
  output logic [ADDR_W-1:0] o_rd_b,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [OP_W-1:0]   o_op,
  output logic              o_sel,
  output logic              o_we,
  output logic              o_clc,
  output logic              o_illegal,
  output logic [DATA_W-1:0] o_d_in
);

  logic w_unused;
  assign w_unused = ^i_instr[RB_LSB-1:0];

  always_comb begin
    o_kind    = i_instr[KIND_MSB:KIND_LSB];
    o_rd_a    = '0;
    o_rd_b    = '0;
    o_wr_addr = '0;
    o_op      = '0;
    o_sel     = 1'b0;
    o_we      = 1'b0;
    o_d_in    = '0;
    o_clc     = (o_kind == K_CLC);
    case (o_kind)
      K_NOP: ;
      K_LDI: begin
        o_wr_addr = i_instr[WA_MSB:WA_LSB];
        o_d_in    = {{(DATA_W-IMM_W){1'b0}}, i_instr[IMM_MSB:0]};
        o_we      = 1'b1;
      end
      K_ALU: begin
        o_rd_a    = i_instr[RA_MSB:RA_LSB];
        o_rd_b    = i_instr[RB_MSB:RB_LSB];
        o_wr_addr = i_instr[WA_MSB:WA_LSB];
        o_op      = i_instr[OP_MSB:OP_LSB];
        o_sel     = 1'b1;
        o_we      = 1'b1;
      end
      K_RD: o_rd_a = i_instr[RA_MSB:RA_LSB];
      default: ;
    endcase
`ifdef REG_ALU_CTRL_CARRY_EN
    o_illegal = o_kind[KIND_W-1] & ~o_clc;
`else
    o_illegal = o_kind[KIND_W-1];
`endif
  end

endmodule

// File: rtl/reg_alu_ctrl.sv
// Instruction controller for the reg_alu datapath: IDLE/DECODE/EXEC/DONE
// sequencer with fully registered outputs. Option: REG_ALU_CTRL_CARRY_EN.
module reg_alu_ctrl
  import reg_alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr,
  output logic              instr_ready,
  output logic              dp_wr,
  output logic              dp_sel,
  output logic [OP_W-1:0]   dp_op,
  output logic [ADDR_W-1:0] dp_rd_addr_a,
  output logic [ADDR_W-1:0] dp_rd_addr_b,
  output logic [ADDR_W-1:0] dp_wr_addr,
  output logic [DATA_W-1:0] dp_d_in,
  input  logic [DATA_W-1:0] dp_d_out_a,
  input  logic              dp_cout,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              done,
  output logic              illegal
`ifdef REG_ALU_CTRL_CARRY_EN
  ,
  output logic              carry
`endif
);

  state_e              r_state, w_next;
  logic [DATA_W-1:0]   r_instr, w_src;
  logic                w_drive;
  logic [KIND_W-1:0]   w_kind;
  logic [ADDR_W-1:0]   w_rd_a, w_rd_b, w_wr_addr;
  logic [OP_W-1:0]     w_op;
  logic                w_sel, w_we, w_clc, w_illegal;
  logic [DATA_W-1:0]   w_d_in;

  logic                r_ready, r_dp_wr, r_dp_sel, r_result_valid, r_done, r_illegal;
  logic [OP_W-1:0]     r_dp_op;
  logic [ADDR_W-1:0]   r_dp_rd_a, r_dp_rd_b, r_dp_wr_addr;
  logic [DATA_W-1:0]   r_dp_d_in, r_result;

  // Decode the live word while accepting it so DECODE-cycle outputs are already registered.
  assign w_src = (r_state == ST_IDLE) ? instr : r_instr;

  reg_alu_ctrl_dec u_dec (
    .i_instr   (w_src),
    .o_kind    (w_kind),
    .o_rd_a    (w_rd_a),
    .o_rd_b    (w_rd_b),
    .o_wr_addr (w_wr_addr),
    .o_op      (w_op),
    .o_sel     (w_sel),
    .o_we      (w_we),
    .o_clc     (w_clc),
    .o_illegal (w_illegal),
    .o_d_in    (w_d_in)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (instr_valid) w_next = ST_DECODE;
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC:   w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    w_drive = (w_next == ST_DECODE) || (w_next == ST_EXEC);
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && instr_valid) r_instr <= instr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_ready        <= 1'b1;
      r_dp_wr        <= 1'b0;
      r_dp_sel       <= 1'b0;
      r_dp_op        <= '0;
      r_dp_rd_a      <= '0;
      r_dp_rd_b      <= '0;
      r_dp_wr_addr   <= '0;
      r_dp_d_in      <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_done         <= 1'b0;
      r_illegal      <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_ready        <= (w_next == ST_IDLE);
      r_dp_wr        <= (w_next == ST_EXEC) && w_we;
      r_dp_sel       <= w_drive & w_sel;
      r_dp_op        <= w_drive ? w_op      : '0;
      r_dp_rd_a      <= w_drive ? w_rd_a    : '0;
      r_dp_rd_b      <= w_drive ? w_rd_b    : '0;
      r_dp_wr_addr   <= w_drive ? w_wr_addr : '0;
      r_dp_d_in      <= w_drive ? w_d_in    : '0;
      r_done         <= (w_next == ST_DONE);
      r_illegal      <= (w_next == ST_DONE) && w_illegal;
      r_result_valid <= 1'b0;
      if (r_state == ST_EXEC && w_kind == K_RD) begin
        r_result       <= dp_d_out_a;
        r_result_valid <= 1'b1;
      end
    end
  end

`ifdef REG_ALU_CTRL_CARRY_EN
  logic r_carry;
  always_ff @(posedge clk) begin
    if (reset) r_carry <= 1'b0;
    else if (r_state == ST_EXEC && w_kind == K_ALU) r_carry <= dp_cout;
    else if (r_state == ST_EXEC && w_clc) r_carry <= 1'b0;
  end
  assign carry = r_carry;
`else
  logic w_unused;
  assign w_unused = dp_cout ^ w_clc;
`endif

  assign instr_ready  = r_ready;
  assign dp_wr        = r_dp_wr;
  assign dp_sel       = r_dp_sel;
  assign dp_op        = r_dp_op;
  assign dp_rd_addr_a = r_dp_rd_a;
  assign dp_rd_addr_b = r_dp_rd_b;
  assign dp_wr_addr   = r_dp_wr_addr;
  assign dp_d_in      = r_dp_d_in;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign done         = r_done;
  assign illegal      = r_illegal;

endmodule
